// File: rtl/stream_downsize_if.sv
// Stream bundle for stream_downsize: wide lane-packed input (s_*) and narrow beat output (m_*).
// The slave modport is the downsizer's view; master is the surrounding environment.
interface stream_downsize_if #(
    parameter int T_DATA_WIDTH = 1,
    parameter int T_DATA_RATIO = 2
);
    logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] s_keep_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic [T_DATA_WIDTH-1:0] m_data_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    modport slave (
        input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_last_o, m_valid_o
    );

    modport master (
        output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits the kept lanes of each word as narrow beats, lowest lane first.
// Optional STREAM_DOWNSIZE_PIPE_EN accepts the next word on the edge the final beat leaves.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 1,
    parameter int T_DATA_RATIO = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_downsize_if.slave  bus,
    output logic              o_dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // m_* is held stable while m_valid_o=1 and m_ready_i=0, and m_* never depends on s_*.
    localparam int IW = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [T_DATA_WIDTH-1:0] r_buf [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] r_mask;
    logic [T_DATA_RATIO-1:0] w_mask_nxt;
    logic [T_DATA_RATIO-1:0] w_cur_onehot;
    logic                    r_last;
    logic [IW-1:0]           w_cur;
    logic                    w_single;
    logic                    w_beat;
    logic                    w_done;
    logic                    w_ready;
    logic                    w_load;
    logic                    w_send;

    // Lowest pending lane; scanning downward leaves the smallest set index last.
    always_comb begin
        w_cur = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_cur = IW'(i);
            end
        end
    end

    assign w_cur_onehot = r_mask & (~r_mask + T_DATA_RATIO'(1));
    assign w_single     = (r_mask & (r_mask - T_DATA_RATIO'(1))) == '0;
    assign w_send       = (r_state == SEND);
    assign w_beat       = w_send && bus.m_ready_i;
    assign w_done       = w_beat && w_single;

`ifdef STREAM_DOWNSIZE_PIPE_EN
    assign w_ready = (r_state == IDLE) || w_done;
`else
    assign w_ready = (r_state == IDLE);
`endif

    assign bus.s_ready_o = w_ready && !rst_n;
    assign w_load        = bus.s_valid_i && bus.s_ready_o;

    assign bus.m_valid_o = w_send;
    assign bus.m_data_o  = w_send ? r_buf[w_cur] : '0;
    assign bus.m_last_o  = w_send && r_last && w_single;
    assign o_dbg_state   = r_state;

    // A load on the final-beat edge overrides the lane clear, giving back-to-back words.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        if (w_beat) begin
            w_mask_nxt = r_mask & ~w_cur_onehot;
            if (w_single) begin
                w_state_nxt = IDLE;
            end
        end
        if (w_load) begin
            w_mask_nxt  = bus.s_keep_i;
            w_state_nxt = (bus.s_keep_i != '0) ? SEND : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_last  <= 1'b0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            if (w_load) begin
                r_buf  <= bus.s_data_i;
                r_last <= bus.s_last_i;
            end
        end
    end
endmodule

// File: tb/tb_stream_downsize.sv
// Directed bench for stream_downsize (8-bit lanes, 4 lanes): vector table plus stall, back-to-back and reset sequences.
module tb_stream_downsize;
    localparam int W = 8;
    localparam int R = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic dbg_state;

    always #5 clk = ~clk;

    stream_downsize_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) bus ();

    stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          n;
        logic [31:0] beats;
        logic [3:0]  lmask;
    } vec_t;

    vec_t        vecs [7];
    logic [9:0]  exp_q [$];   // {final beat of word, m_last, m_data}
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        for (int i = 0; i < R; i++) bus.s_data_i[i] = d[8*i +: 8];
        bus.s_keep_i  = k;
        bus.s_last_i  = l;
        bus.s_valid_i = 1'b1;
    endtask

    task automatic push_exp(input logic [31:0] beats, input logic [3:0] lmask, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), lmask[k], beats[8*k +: 8]});
    endtask

    // Called while m_valid_o=1 and m_ready_i=1.
    task automatic check_beat();
        logic [9:0] e;
        check("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("beat_last_data", {bus.m_last_o, bus.m_data_o}, e[8:0]);
`ifdef STREAM_DOWNSIZE_PIPE_EN
            check("s_ready_send", bus.s_ready_o, e[9]);
`else
            check("s_ready_send", bus.s_ready_o, 0);
`endif
        end
    endtask

    // Starts and ends at a negedge.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        drive_word(d, k, l);
        #1;
        n = 0;
        while (!bus.s_ready_o && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("s_ready_accept", bus.s_ready_o, 1);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid_i = 1'b0;
    endtask

    task automatic collect(input logic [15:0] pat, input int n_exp, input int budget);
        int         got;
        int         c;
        int         first;
        logic       prev_stall;
        logic [8:0] prev_beat;
        got        = 0;
        c          = 0;
        first      = -1;
        prev_stall = 1'b0;
        prev_beat  = '0;
        while (got < n_exp && c < budget) begin
            bus.m_ready_i = (c < 16) ? pat[c] : 1'b1;
            #1;
            if (prev_stall)
                check("hold_stable", {bus.m_valid_o, bus.m_last_o, bus.m_data_o}, {1'b1, prev_beat});
            if (bus.m_valid_o) begin
                if (first < 0) first = c;
                if (bus.m_ready_i) begin
                    got++;
                    check_beat();
                end else begin
                    check("s_ready_stall", bus.s_ready_o, 0);
                end
            end
            prev_stall = bus.m_valid_o && !bus.m_ready_i;
            prev_beat  = {bus.m_last_o, bus.m_data_o};
            c++;
            @(negedge clk);
        end
        check("beat_count", got, n_exp);
        if (n_exp > 0) check("first_latency", first, 0);
        bus.m_ready_i = 1'b1;
        repeat (2) begin
            #1;
            check("idle_valid", bus.m_valid_o, 0);
            check("idle_ready", bus.s_ready_o, 1);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nb;
        int         idx;
        int         bc [8];
        logic       acc;
        int         gap;

        vecs[0] = '{32'h44332211, 4'hF,    1'b1, 4, 32'h44332211, 4'b1000};
        vecs[1] = '{32'hDDCCBBAA, 4'b1010, 1'b1, 2, 32'h0000DDBB, 4'b0010};
        vecs[2] = '{32'h12345678, 4'h0,    1'b1, 0, 32'h00000000, 4'b0000};
        vecs[3] = '{32'h87654321, 4'b0001, 1'b0, 1, 32'h00000021, 4'b0000};
        vecs[4] = '{32'h87654321, 4'b1000, 1'b1, 1, 32'h00000087, 4'b0001};
        vecs[5] = '{32'hA5B6C7D8, 4'b0110, 1'b0, 2, 32'h0000B6C7, 4'b0000};
        vecs[6] = '{32'h0F1E2D3C, 4'b0111, 1'b1, 3, 32'h001E2D3C, 4'b0100};

        for (int i = 0; i < R; i++) bus.s_data_i[i] = '0;
        bus.s_keep_i  = '0;
        bus.s_last_i  = 1'b0;
        bus.s_valid_i = 1'b1;
        bus.m_ready_i = 1'b0;

        // Reset held (rst_n=1 is the asserted level)
        #2;
        check("rst_valid", bus.m_valid_o, 0);
        check("rst_last",  bus.m_last_o, 0);
        check("rst_data",  bus.m_data_o, 0);
        check("rst_ready", bus.s_ready_o, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("post_rst_ready", bus.s_ready_o, 1);
        @(negedge clk);

        // Table-driven words with m_ready held high
        for (int v = 0; v < 7; v++) begin
            push_exp(vecs[v].beats, vecs[v].lmask, vecs[v].n);
            send(vecs[v].data, vecs[v].keep, vecs[v].last);
            collect(16'hFFFF, vecs[v].n, 20);
        end

        // Stall pattern 1,0,0,1,1,0,1 on a full word
        push_exp(32'h44332211, 4'b1000, 4);
        send(32'h44332211, 4'hF, 1'b1);
        collect(16'h0059, 4, 20);

        // Two full words back-to-back
        push_exp(32'h44332211, 4'b0000, 4);
        push_exp(32'h88776655, 4'b1000, 4);
        nb  = 0;
        idx = 0;
        for (int i = 0; i < 8; i++) bc[i] = -1;
        drive_word(32'h44332211, 4'hF, 1'b0);
        bus.m_ready_i = 1'b1;
        for (int c = 0; c < 30 && nb < 8; c++) begin
            #1;
            if (bus.m_valid_o) begin
                check_beat();
                bc[nb] = c;
                nb++;
            end
            acc = bus.s_valid_i && bus.s_ready_o;
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx == 1) drive_word(32'h88776655, 4'hF, 1'b1);
                else bus.s_valid_i = 1'b0;
            end
        end
        bus.s_valid_i = 1'b0;
`ifdef STREAM_DOWNSIZE_PIPE_EN
        gap = 1;
`else
        gap = 2;
`endif
        check("b2b_count",  nb, 8);
        check("b2b_first",  bc[0], 1);
        check("b2b_beat4",  bc[3], 4);
        check("b2b_beat5",  bc[4], 4 + gap);
        check("b2b_beat8",  bc[7], 7 + gap);
        #1;
        check("b2b_idle", bus.m_valid_o, 0);
        @(negedge clk);

        // Reset after two beats of a word
        send(32'h44332211, 4'hF, 1'b1);
        bus.m_ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("pre_rst_valid", bus.m_valid_o, 1);
            check("pre_rst_beat", {bus.m_last_o, bus.m_data_o}, {1'b0, 8'(8'h11 * (c + 1))});
            @(negedge clk);
        end
        #2;
        rst_n = 1'b1;
        #1;
        check("mid_rst_valid", bus.m_valid_o, 0);
        check("mid_rst_data",  bus.m_data_o, 0);
        check("mid_rst_ready", bus.s_ready_o, 0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) begin
            #1;
            check("after_rst_valid", bus.m_valid_o, 0);
            @(negedge clk);
        end
        push_exp(32'hD4C3B2A1, 4'b1000, 4);
        send(32'hD4C3B2A1, 4'hF, 1'b1);
        collect(16'hFFFF, 4, 20);

        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
